move_step_sequencer: RTL

Parametrised control-step sequencer for the DataPath. It generates fetch (T0–T2) and execute (T3) control strobes for the special-register move family: mfhi, mflo, mthi and mtlo. The block replaces hand-timed step sequencing and adds:
- configurable per-step hold length
- a memory-ready handshake with timeout
- single-instruction or free-running mode
- illegal-opcode fault reporting

It sits between the IR opcode field and the DataPath control inputs.

---
 rtl/move_step_sequencer_pkg.sv | 39 +++
 rtl/move_step_sequencer_if.sv | 26 ++
 rtl/move_step_sequencer_step_timer.sv | 32 +++
 rtl/move_step_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/move_step_sequencer_pkg.sv
// Shared constants for the special-register move step sequencer:
// step encodings, ctrl strobe bit positions and default opcodes.
package cpu_ctrl_pkg;

  localparam int CTRL_W = 17;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_T0    = 3'd1,
    ST_T1    = 3'd2,
    ST_T2    = 3'd3,
    ST_T3    = 3'd4,
    ST_FAULT = 3'd7
  } step_e;

  localparam int C_PCOUT   = 0;
  localparam int C_MARIN   = 1;
  localparam int C_INCPC   = 2;
  localparam int C_RZIN    = 3;
  localparam int C_RZLOOUT = 4;
  localparam int C_PCIN    = 5;
  localparam int C_READ    = 6;
  localparam int C_MDRIN   = 7;
  localparam int C_MDROUT  = 8;
  localparam int C_IRIN    = 9;
  localparam int C_GRA     = 10;
  localparam int C_RIN     = 11;
  localparam int C_ROUT    = 12;
  localparam int C_HIOUT   = 13;
  localparam int C_LOOUT   = 14;
  localparam int C_HIIN    = 15;
  localparam int C_LOIN    = 16;

  localparam int DEF_OP_MFHI = 24;
  localparam int DEF_OP_MFLO = 25;
  localparam int DEF_OP_MTHI = 26;
  localparam int DEF_OP_MTLO = 27;

endpackage

// File: rtl/move_step_sequencer_if.sv
// Handshake/strobe bundle between the IR/memory side and the step sequencer.
interface move_step_sequencer_if
  import cpu_ctrl_pkg::*;
#(
  parameter int OP_W = 5
);
  logic              start;
  logic              run;
  logic [OP_W-1:0]   ir_op;
  logic              mem_ready;
  logic [CTRL_W-1:0] ctrl;
  logic [2:0]        state;
  logic              busy;
  logic              done;
  logic              fault;

  modport master (
    output start, run, ir_op, mem_ready,
    input  ctrl, state, busy, done, fault
  );

  modport slave (
    input  start, run, ir_op, mem_ready,
    output ctrl, state, busy, done, fault
  );
endinterface

// File: rtl/move_step_sequencer_step_timer.sv
// Per-step cycle counter: holds the 1-based cycle index within the current step.
module step_timer #(
  parameter int STEP_HOLD   = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic clear,
  input  logic restart,
  output logic hold_done,
  output logic timeout
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(STEP_HOLD);
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q;

  // restart loads 1 because the entry cycle itself is the first cycle of the step
  always_ff @(posedge clock) begin
    if (!clear) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q != TO_CNT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign hold_done = (cnt_q >= HOLD_CNT);
  assign timeout   = (cnt_q >= TO_CNT);

endmodule

// File: rtl/move_step_sequencer.sv
// Fetch/execute step sequencer for mfhi/mflo/mthi/mtlo: drives DataPath
// strobes per step, waits on mem_ready in T1 and traps illegal opcodes.
module move_step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int              OP_W        = 5,
  parameter int              STEP_HOLD   = 1,
  parameter int              MEM_TIMEOUT = 15,
  parameter logic [OP_W-1:0] OP_MFHI     = OP_W'(DEF_OP_MFHI),
  parameter logic [OP_W-1:0] OP_MFLO     = OP_W'(DEF_OP_MFLO),
  parameter logic [OP_W-1:0] OP_MTHI     = OP_W'(DEF_OP_MTHI),
  parameter logic [OP_W-1:0] OP_MTLO     = OP_W'(DEF_OP_MTLO)
) (
  input  logic                  clock,
  input  logic                  clear,
  move_step_sequencer_if.slave  bus
);

  step_e             state_q, state_nx;
  logic              seen_rdy_q;
  logic              done_q;
  logic              fault_q;
  logic              step_entry;
  logic              hold_done;
  logic              timeout;
  logic              op_legal;
  logic [CTRL_W-1:0] ctrl;

  assign op_legal = (bus.ir_op == OP_MFHI) || (bus.ir_op == OP_MFLO) ||
                    (bus.ir_op == OP_MTHI) || (bus.ir_op == OP_MTLO);

  assign step_entry = (state_nx != state_q);

  step_timer #(
    .STEP_HOLD   (STEP_HOLD),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clock     (clock),
    .clear     (clear),
    .restart   (step_entry),
    .hold_done (hold_done),
    .timeout   (timeout)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q    <= ST_IDLE;
      seen_rdy_q <= 1'b0;
      done_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_nx;
      seen_rdy_q <= step_entry ? 1'b0 : (seen_rdy_q | ((state_q == ST_T1) & bus.mem_ready));
      done_q     <= (state_q == ST_T3) & op_legal & hold_done;
      fault_q    <= (state_nx == ST_FAULT);
    end
  end

  // ready on the timeout cycle still wins because it is tested first
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start) state_nx = ST_T0;
      ST_T0:    if (hold_done) state_nx = ST_T1;
      ST_T1: begin
        if ((bus.mem_ready || seen_rdy_q) && hold_done) state_nx = ST_T2;
        else if (timeout)                               state_nx = ST_FAULT;
      end
      ST_T2:    if (hold_done) state_nx = ST_T3;
      ST_T3: begin
        if (!op_legal)      state_nx = ST_FAULT;
        else if (hold_done) state_nx = bus.run ? ST_T0 : ST_IDLE;
      end
      ST_FAULT: state_nx = ST_FAULT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // strobes depend on the current step (and ir_op in T3) only
  always_comb begin
    ctrl = '0;
    case (state_q)
      ST_T0: begin
        ctrl[C_PCOUT] = 1'b1;
        ctrl[C_MARIN] = 1'b1;
        ctrl[C_INCPC] = 1'b1;
        ctrl[C_RZIN]  = 1'b1;
      end
      ST_T1: begin
        ctrl[C_RZLOOUT] = 1'b1;
        ctrl[C_PCIN]    = 1'b1;
        ctrl[C_READ]    = 1'b1;
        ctrl[C_MDRIN]   = 1'b1;
      end
      ST_T2: begin
        ctrl[C_MDROUT] = 1'b1;
        ctrl[C_IRIN]   = 1'b1;
      end
      ST_T3: begin
        if (bus.ir_op == OP_MFHI) begin
          ctrl[C_GRA]   = 1'b1;
          ctrl[C_RIN]   = 1'b1;
          ctrl[C_HIOUT] = 1'b1;
        end else if (bus.ir_op == OP_MFLO) begin
          ctrl[C_GRA]   = 1'b1;
          ctrl[C_RIN]   = 1'b1;
          ctrl[C_LOOUT] = 1'b1;
        end else if (bus.ir_op == OP_MTHI) begin
          ctrl[C_GRA]  = 1'b1;
          ctrl[C_ROUT] = 1'b1;
          ctrl[C_HIIN] = 1'b1;
        end else if (bus.ir_op == OP_MTLO) begin
          ctrl[C_GRA]  = 1'b1;
          ctrl[C_ROUT] = 1'b1;
          ctrl[C_LOIN] = 1'b1;
        end
      end
      default: ctrl = '0;
    endcase
  end

  assign bus.ctrl  = ctrl;
  assign bus.state = state_q;
  assign bus.busy  = (state_q == ST_T0) || (state_q == ST_T1) ||
                     (state_q == ST_T2) || (state_q == ST_T3);
  assign bus.done  = done_q;
  assign bus.fault = fault_q;

endmodule
